lf_spi_conf: RTL and testbench

- Next-generation LF configuration receiver. It replaces the ncs/spck-clocked config logic with an SPI slave oversampled in the pck0 domain.
- Decodes 16-bit command frames into conf_word, divisor and NUM_USER user bytes.
- Validates frame length, reads back the last accepted frame on miso, and produces a one-hot major-mode select for the LF top-level output muxes.

---
 rtl/lf_conf_pkg.sv | 21 ++
 rtl/lf_sync_edge.sv | 36 +++
 rtl/lf_spi_conf.sv | 156 +++++++++++++++
 tb/tb_lf_spi_conf.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lf_conf_pkg.sv
// rtl/lf_conf_pkg.sv - shared command/mode codes and frame width for the LF config receiver
// Contents: cmd_e (SPI command nibble), mode_e (major-mode field of conf_word), FRAME_W_DEFAULT.
package lf_conf_pkg;

  localparam int FRAME_W_DEFAULT = 16;

  // Command nibble carried in the top four bits of each frame.
  typedef enum logic [3:0] {
    CMD_SET_CONF      = 4'd1,
    CMD_SET_DIVISOR   = 4'd2,
    CMD_SET_USER_BASE = 4'd3
  } cmd_e;

  // Major-mode field, conf_word[7:5].
  typedef enum logic [2:0] {
    MODE_READER      = 3'd0,
    MODE_EDGE_DETECT = 3'd1,
    MODE_PASSTHRU    = 3'd2
  } mode_e;

endpackage

// File: rtl/lf_sync_edge.sv
// rtl/lf_sync_edge.sv - multi-flop synchroniser with rise/fall pulse outputs
// Ports:
//   clk, resetn : sampling clock, synchronous active-low reset
//   d           : asynchronous input
//   level       : synchronised level (RESET_VAL while in reset)
//   rise, fall  : one-cycle pulses on 0->1 / 1->0 transitions of level
module lf_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/lf_spi_conf.sv
// rtl/lf_spi_conf.sv - SPI-slave configuration receiver oversampled in the pck0 domain
// Ports:
//   pck0, nreset         : system clock, synchronous active-low reset
//   spck, mosi, ncs      : asynchronous SPI slave pins (mode 0, MSB first)
//   miso                 : readback of the last accepted frame, 0 while ncs is high
//   conf_word, major_mode: configuration word and its [7:5] mode field
//   mode_sel, mode_valid : one-hot mode select (all zero when the mode is unimplemented)
//   divisor, user_bytes  : divisor and packed user bytes (byte k at [8k+7:8k])
//   cfg_update, frame_err: one-cycle pulses on register write / frame rejection
module lf_spi_conf
  import lf_conf_pkg::*;
#(
  parameter int FRAME_W           = FRAME_W_DEFAULT,
  parameter int NUM_USER          = 2,
  parameter int NUM_MODES         = 3,
  parameter int SYNC_STAGES       = 2,
  parameter int DIV_DEFAULT       = 95,
  parameter int ED_THRESH_DEFAULT = 127
) (
  input  logic                  pck0,
  input  logic                  nreset,
  input  logic                  spck,
  input  logic                  mosi,
  input  logic                  ncs,
  output logic                  miso,
  output logic [7:0]            conf_word,
  output logic [2:0]            major_mode,
  output logic [NUM_MODES-1:0]  mode_sel,
  output logic                  mode_valid,
  output logic [7:0]            divisor,
  output logic [8*NUM_USER-1:0] user_bytes,
  output logic                  cfg_update,
  output logic                  frame_err
);

  // Counter saturates one past a full frame so long frames stay distinguishable.
  localparam int                CNT_W    = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic spck_lvl, spck_rise, spck_fall_unused;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  lf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_spck (
    .clk    (pck0),
    .resetn (nreset),
    .d      (spck),
    .level  (spck_lvl),
    .rise   (spck_rise),
    .fall   (spck_fall_unused)
  );

  lf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk    (pck0),
    .resetn (nreset),
    .d      (ncs),
    .level  (ncs_lvl),
    .rise   (ncs_rise),
    .fall   (ncs_fall)
  );

  lf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (pck0),
    .resetn (nreset),
    .d      (mosi),
    .level  (mosi_lvl),
    .rise   (mosi_rise_unused),
    .fall   (mosi_fall_unused)
  );

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] readback;
  logic [FRAME_W-1:0] miso_sh;
  logic [7:0]         user_byte [NUM_USER];

  logic [3:0] cmd;
  logic [7:0] data;
  logic       cmd_user;
  logic       cmd_ok;

  assign cmd  = shift_reg[FRAME_W-1 -: 4];
  assign data = shift_reg[7:0];

  always_comb begin
    cmd_user = 1'b0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (int'(cmd) == int'(CMD_SET_USER_BASE) + k) cmd_user = 1'b1;
    end
    cmd_ok = (cmd == CMD_SET_CONF) || (cmd == CMD_SET_DIVISOR) || cmd_user;
  end

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      readback   <= '0;
      miso_sh    <= '0;
      conf_word  <= '0;
      divisor    <= 8'(DIV_DEFAULT);
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      for (int k = 0; k < NUM_USER; k++) user_byte[k] <= '0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;

      if (ncs_fall) begin
        bit_cnt <= '0;
        miso_sh <= readback;
      end else if (spck_rise && !ncs_lvl) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_lvl};
        miso_sh   <= {miso_sh[FRAME_W-2:0], 1'b0};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end

      // A spck rise in the ncs-rise cycle is already excluded above (ncs_lvl is 1).
      if (ncs_rise) begin
        if (bit_cnt == CNT_FULL && cmd_ok) begin
          cfg_update <= 1'b1;
          readback   <= shift_reg;
          if (cmd == CMD_SET_CONF) begin
            conf_word <= data;
            if (data[7:5] == MODE_EDGE_DETECT) user_byte[0] <= 8'(ED_THRESH_DEFAULT);
          end
          if (cmd == CMD_SET_DIVISOR) divisor <= data;
          for (int k = 0; k < NUM_USER; k++) begin
            if (int'(cmd) == int'(CMD_SET_USER_BASE) + k) user_byte[k] <= data;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  // Suppress the stale shifter MSB during the ncs-fall cycle, before the reload lands.
  assign miso = ~ncs_lvl & ~ncs_fall & miso_sh[FRAME_W-1];

  always_comb begin
    user_bytes = '0;
    for (int k = 0; k < NUM_USER; k++) user_bytes[8*k +: 8] = user_byte[k];
  end

  assign major_mode = conf_word[7:5];
  assign mode_valid = int'(major_mode) < NUM_MODES;

  always_comb begin
    mode_sel = '0;
    if (mode_valid) begin
      for (int i = 0; i < NUM_MODES; i++) mode_sel[i] = (int'(major_mode) == i);
    end
  end

endmodule

// File: tb/tb_lf_spi_conf.sv
// tb/tb_lf_spi_conf.sv - directed self-checking bench for lf_spi_conf
module tb_lf_spi_conf;

  logic        pck0 = 1'b0;
  logic        nreset;
  logic        spck, mosi, ncs;
  logic        miso;
  logic [7:0]  conf_word;
  logic [2:0]  major_mode;
  logic [2:0]  mode_sel;
  logic        mode_valid;
  logic [7:0]  divisor;
  logic [15:0] user_bytes;
  logic        cfg_update, frame_err;

  int checks = 0;
  int errors = 0;

  always #5 pck0 = ~pck0;

  lf_spi_conf dut (
    .pck0       (pck0),
    .nreset     (nreset),
    .spck       (spck),
    .mosi       (mosi),
    .ncs        (ncs),
    .miso       (miso),
    .conf_word  (conf_word),
    .major_mode (major_mode),
    .mode_sel   (mode_sel),
    .mode_valid (mode_valid),
    .divisor    (divisor),
    .user_bytes (user_bytes),
    .cfg_update (cfg_update),
    .frame_err  (frame_err)
  );

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge pck0);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SPI mode-0 bit: data set up, miso sampled just before the rising edge.
  task automatic xfer_bit(input logic b, output logic m);
    mosi = b;
    wait_cyc(4);
    m = miso;
    spck = 1'b1;
    wait_cyc(4);
    spck = 1'b0;
  endtask

  task automatic frame(input logic [31:0] val, input int n,
                       output logic [31:0] rx, output int n_cfg, output int n_err);
    logic [31:0] v;
    logic        m;
    v = val;
    rx = '0;
    ncs = 1'b0;
    wait_cyc(4);
    for (int i = n - 1; i >= 0; i--) begin
      xfer_bit(v[i], m);
      rx = {rx[30:0], m};
    end
    wait_cyc(4);
    ncs = 1'b1;
    n_cfg = 0;
    n_err = 0;
    repeat (12) begin
      wait_cyc(1);
      if (cfg_update) n_cfg++;
      if (frame_err) n_err++;
    end
    wait_cyc(4);
  endtask

  logic [31:0] rx;
  int          n_cfg, n_err;
  logic        m;

  initial begin
    nreset = 1'b0;
    ncs    = 1'b1;
    spck   = 1'b0;
    mosi   = 1'b0;
    wait_cyc(3);
    nreset = 1'b1;
    wait_cyc(2);

    chk("rst_conf",    32'(conf_word),  32'h00);
    chk("rst_div",     32'(divisor),    32'h5F);
    chk("rst_user",    32'(user_bytes), 32'h0000);
    chk("rst_modesel", 32'(mode_sel),   32'b001);
    chk("rst_miso",    32'(miso),       32'h0);
    chk("rst_cfgupd",  32'(cfg_update), 32'h0);
    chk("rst_ferr",    32'(frame_err),  32'h0);

    frame(32'h1021, 16, rx, n_cfg, n_err);
    chk("f1021_cfg",     32'(n_cfg),      32'd1);
    chk("f1021_err",     32'(n_err),      32'd0);
    chk("f1021_conf",    32'(conf_word),  32'h21);
    chk("f1021_major",   32'(major_mode), 32'd1);
    chk("f1021_modesel", 32'(mode_sel),   32'b010);
    chk("f1021_valid",   32'(mode_valid), 32'd1);
    chk("f1021_user",    32'(user_bytes), 32'h007F);
    chk("f1021_rx",      rx,              32'h0000);

    frame(32'h2057, 16, rx, n_cfg, n_err);
    chk("f2057_cfg", 32'(n_cfg),   32'd1);
    chk("f2057_div", 32'(divisor), 32'h57);
    chk("f2057_rx",  rx,           32'h1021);

    frame(32'h3010, 16, rx, n_cfg, n_err);
    chk("f3010_cfg",  32'(n_cfg),      32'd1);
    chk("f3010_user", 32'(user_bytes), 32'h0010);
    chk("f3010_rx",   rx,              32'h2057);

    frame(32'h2011, 15, rx, n_cfg, n_err);
    chk("short_err",  32'(n_err),      32'd1);
    chk("short_cfg",  32'(n_cfg),      32'd0);
    chk("short_rx",   rx,              32'h1808);
    chk("short_div",  32'(divisor),    32'h57);

    frame(32'h12345, 17, rx, n_cfg, n_err);
    chk("long_err",   32'(n_err),      32'd1);
    chk("long_cfg",   32'(n_cfg),      32'd0);
    chk("long_rx",    rx,              32'h6020);
    chk("long_conf",  32'(conf_word),  32'h21);
    chk("long_div",   32'(divisor),    32'h57);
    chk("long_user",  32'(user_bytes), 32'h0010);

    frame(32'h9033, 16, rx, n_cfg, n_err);
    chk("bad_cmd_err",  32'(n_err),      32'd1);
    chk("bad_cmd_cfg",  32'(n_cfg),      32'd0);
    chk("bad_cmd_user", 32'(user_bytes), 32'h0010);
    chk("bad_cmd_rx",   rx,              32'h3010);

    frame(32'h10E0, 16, rx, n_cfg, n_err);
    chk("f10e0_cfg",     32'(n_cfg),      32'd1);
    chk("f10e0_conf",    32'(conf_word),  32'hE0);
    chk("f10e0_valid",   32'(mode_valid), 32'd0);
    chk("f10e0_modesel", 32'(mode_sel),   32'b000);
    chk("f10e0_user",    32'(user_bytes), 32'h0010);
    chk("f10e0_rx",      rx,              32'h3010);

    // Reset in the middle of a frame.
    ncs = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 8; i++) xfer_bit(1'b1, m);
    nreset = 1'b0;
    wait_cyc(2);
    nreset = 1'b1;
    wait_cyc(1);
    chk("midrst_conf",    32'(conf_word),  32'h00);
    chk("midrst_div",     32'(divisor),    32'h5F);
    chk("midrst_user",    32'(user_bytes), 32'h0000);
    chk("midrst_modesel", 32'(mode_sel),   32'b001);
    ncs = 1'b1;
    wait_cyc(12);

    frame(32'h4011, 16, rx, n_cfg, n_err);
    chk("f4011_cfg",  32'(n_cfg),      32'd1);
    chk("f4011_err",  32'(n_err),      32'd0);
    chk("f4011_user", 32'(user_bytes), 32'h1100);
    chk("f4011_rx",   rx,              32'h0000);
    chk("f4011_div",  32'(divisor),    32'h5F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
